// File: rtl/flashing_borders.sv
// Table frame drawer: per-pixel side decode with per-side hit-triggered flashing, registered outputs.
// Optional macro BORDER_POCKET_GAPS_EN cuts square pocket gaps at corners and side midpoints.
module flashing_borders #(
  parameter int unsigned LEFT_OFFSET   = 32,
  parameter int unsigned RIGHT_OFFSET  = 607,
  parameter int unsigned TOP_OFFSET    = 32,
  parameter int unsigned DOWN_OFFSET   = 447,
  parameter int unsigned THICKNESS     = 16,
  parameter logic [7:0]  BORDER_COLOR  = 8'hAC,
  parameter logic [7:0]  FLASH_COLOR   = 8'hFF,
  parameter int unsigned FLASH_FRAMES  = 8,
  parameter int unsigned BLINK_PERIOD  = 2,
  parameter int unsigned POCKET_RADIUS = 12
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        hitTop,
  input  logic        hitDown,
  input  logic        hitLeft,
  input  logic        hitRight,
  output logic        drawingRequestBorders,
  output logic [7:0]  RGBoutBorders,
  output logic [3:0]  borderSide,
  output logic [3:0]  flashActive
);

  if (LEFT_OFFSET < THICKNESS || TOP_OFFSET < THICKNESS) begin : gen_bad_offsets
    $error("flashing_borders: LEFT_OFFSET and TOP_OFFSET must be >= THICKNESS");
  end
  if (FLASH_FRAMES < 1 || FLASH_FRAMES > 255 || BLINK_PERIOD < 1 || BLINK_PERIOD > 15)
  begin : gen_bad_timing
    $error("flashing_borders: FLASH_FRAMES or BLINK_PERIOD out of range");
  end

  localparam logic [11:0] XOuterL = 12'(LEFT_OFFSET - THICKNESS);
  localparam logic [11:0] XInnerL = 12'(LEFT_OFFSET);
  localparam logic [11:0] XInnerR = 12'(RIGHT_OFFSET);
  localparam logic [11:0] XOuterR = 12'(RIGHT_OFFSET + THICKNESS);
  localparam logic [11:0] YOuterT = 12'(TOP_OFFSET - THICKNESS);
  localparam logic [11:0] YInnerT = 12'(TOP_OFFSET);
  localparam logic [11:0] YInnerD = 12'(DOWN_OFFSET);
  localparam logic [11:0] YOuterD = 12'(DOWN_OFFSET + THICKNESS);
  localparam logic [7:0]  FrameLoad = 8'(FLASH_FRAMES);
  localparam logic [3:0]  BlinkLast = 4'(BLINK_PERIOD - 1);

  typedef enum logic {StIdle, StFlash} state_e;

  state_e     state_q     [4];
  logic [7:0] frame_cnt_q [4];
  logic [3:0] blink_cnt_q [4];
  logic [3:0] phase_q;
  logic [3:0] hits;
  logic [3:0] flash_now;
  logic [3:0] side_raw;
  logic [3:0] side_d;
  logic [11:0] x;
  logic [11:0] y;
  logic        x_span;
  logic        y_span;

  assign hits = {hitRight, hitLeft, hitDown, hitTop};
  assign x    = {1'b0, pixelX};
  assign y    = {1'b0, pixelY};

`ifdef BORDER_POCKET_GAPS_EN
  localparam logic [11:0] PocketR = 12'(POCKET_RADIUS);
  localparam logic [11:0] XMid    = 12'((LEFT_OFFSET + RIGHT_OFFSET) >> 1);

  // |a - c| < R without signed arithmetic
  function automatic logic near(input logic [11:0] a, input logic [11:0] c);
    return (a + PocketR > c) && (c + PocketR > a);
  endfunction

  logic in_pocket;
  always_comb begin
    in_pocket = (near(y, YInnerT) || near(y, YInnerD)) &&
                (near(x, XInnerL) || near(x, XInnerR) || near(x, XMid));
  end
`else
  logic unused_pocket;
  assign unused_pocket = ^POCKET_RADIUS;
`endif

  always_comb begin
    x_span      = (x >= XOuterL) && (x <= XOuterR);
    y_span      = (y >= YOuterT) && (y <= YOuterD);
    side_raw[0] = x_span && (y >= YOuterT) && (y < YInnerT);
    side_raw[1] = x_span && (y > YInnerD) && (y <= YOuterD);
    side_raw[2] = y_span && (x >= XOuterL) && (x < XInnerL);
    side_raw[3] = y_span && (x > XInnerR) && (x <= XOuterR);
`ifdef BORDER_POCKET_GAPS_EN
    side_d = in_pocket ? 4'b0000 : side_raw;
`else
    side_d = side_raw;
`endif
    for (int i = 0; i < 4; i++) begin
      flash_now[i] = (state_q[i] == StFlash) && phase_q[i];
    end
  end

  // Per-side flash FSMs; a hit reload takes priority over the frame tick.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i]     <= StIdle;
        frame_cnt_q[i] <= 8'd0;
        blink_cnt_q[i] <= 4'd0;
      end
      phase_q <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (hits[i]) begin
          state_q[i]     <= StFlash;
          frame_cnt_q[i] <= FrameLoad;
          blink_cnt_q[i] <= 4'd0;
          phase_q[i]     <= 1'b1;
        end else if (state_q[i] == StFlash && startOfFrame) begin
          frame_cnt_q[i] <= frame_cnt_q[i] - 8'd1;
          if (blink_cnt_q[i] == BlinkLast) begin
            blink_cnt_q[i] <= 4'd0;
            phase_q[i]     <= ~phase_q[i];
          end else begin
            blink_cnt_q[i] <= blink_cnt_q[i] + 4'd1;
          end
          if (frame_cnt_q[i] == 8'd1) begin
            state_q[i] <= StIdle;
            phase_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Outputs use the FSM state as it stood before this edge's update.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequestBorders <= 1'b0;
      RGBoutBorders         <= 8'h00;
      borderSide            <= 4'b0000;
      flashActive           <= 4'b0000;
    end else begin
      drawingRequestBorders <= |side_d;
      borderSide            <= side_d;
      if (side_d == 4'b0000) begin
        RGBoutBorders <= 8'h00;
      end else if (|(side_d & flash_now)) begin
        RGBoutBorders <= FLASH_COLOR;
      end else begin
        RGBoutBorders <= BORDER_COLOR;
      end
      for (int i = 0; i < 4; i++) begin
        flashActive[i] <= (state_q[i] == StFlash);
      end
    end
  end

endmodule

// File: tb/tb_flashing_borders.sv
// Scoreboard bench for flashing_borders: stimulus pushes expectations, a monitor pops and compares.
// Covers region decode, flash/blink timing, retrigger, shared corners, async reset, pocket macro.
module tb_flashing_borders;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        hitTop = 1'b0, hitDown = 1'b0, hitLeft = 1'b0, hitRight = 1'b0;
  logic        drawingRequestBorders;
  logic [7:0]  RGBoutBorders;
  logic [3:0]  borderSide;
  logic [3:0]  flashActive;

  flashing_borders dut (
    .clk                   (clk),
    .resetN                (resetN),
    .startOfFrame          (startOfFrame),
    .pixelX                (pixelX),
    .pixelY                (pixelY),
    .hitTop                (hitTop),
    .hitDown               (hitDown),
    .hitLeft               (hitLeft),
    .hitRight              (hitRight),
    .drawingRequestBorders (drawingRequestBorders),
    .RGBoutBorders         (RGBoutBorders),
    .borderSide            (borderSide),
    .flashActive           (flashActive)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       draw;
    logic [3:0] side;
    logic [7:0] rgb;
    logic [3:0] flash;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic vld = 1'b0;
  logic vld_d = 1'b0;

  always @(posedge clk) vld_d <= vld;

  task automatic compare(input string nm, input logic draw, input logic [3:0] side,
                         input logic [7:0] rgb, input logic [3:0] flash);
    n_vec++;
    if (drawingRequestBorders !== draw || borderSide !== side || RGBoutBorders !== rgb ||
        flashActive !== flash) begin
      n_bad++;
      $display("FAIL %s: got draw=%b side=%b rgb=%h flash=%b, want draw=%b side=%b rgb=%h flash=%b",
               nm, drawingRequestBorders, borderSide, RGBoutBorders, flashActive,
               draw, side, rgb, flash);
    end
  endtask

  // Monitor: one cycle after a vector is applied, the registered outputs answer it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (vld_d) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL scoreboard: output presented with empty queue");
        end else begin
          e = exp_q.pop_front();
          compare(e.name, e.draw, e.side, e.rgb, e.flash);
        end
      end
    end
  end

  task automatic vec(input string nm, input int x, input int y, input logic draw,
                     input logic [3:0] side, input logic [7:0] rgb, input logic [3:0] flash);
    exp_t e;
    @(negedge clk);
    pixelX = 11'(x);
    pixelY = 11'(y);
    e.name = nm; e.draw = draw; e.side = side; e.rgb = rgb; e.flash = flash;
    exp_q.push_back(e);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic sof(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
    end
  endtask

  task automatic hit(input logic [3:0] h, input logic with_sof);
    @(negedge clk);
    {hitRight, hitLeft, hitDown, hitTop} = h;
    startOfFrame = with_sof;
    @(negedge clk);
    {hitRight, hitLeft, hitDown, hitTop} = 4'b0000;
    startOfFrame = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pixelX = 11'd100;
    pixelY = 11'd20;
    #12;
    compare("reset_state", 1'b0, 4'b0000, 8'h00, 4'b0000);
    @(negedge clk);
    resetN = 1'b1;

    // Region decode
    vec("top_100_20",    100, 20,  1'b1, 4'b0001, 8'hAC, 4'b0000);
    vec("left_20_200",   20,  200, 1'b1, 4'b0100, 8'hAC, 4'b0000);
    vec("corner_20_20",  20,  20,  1'b1, 4'b0101, 8'hAC, 4'b0000);
    vec("inside_320",    320, 240, 1'b0, 4'b0000, 8'h00, 4'b0000);
    vec("outside_5_5",   5,   5,   1'b0, 4'b0000, 8'h00, 4'b0000);
    vec("outer_16_16",   16,  16,  1'b1, 4'b0101, 8'hAC, 4'b0000);
    vec("beyond_15_16",  15,  16,  1'b0, 4'b0000, 8'h00, 4'b0000);
    vec("corner_rd",     623, 463, 1'b1, 4'b1010, 8'hAC, 4'b0000);
    vec("beyond_624",    624, 100, 1'b0, 4'b0000, 8'h00, 4'b0000);
    vec("right_608_100", 608, 100, 1'b1, 4'b1000, 8'hAC, 4'b0000);
    vec("down_100_448",  100, 448, 1'b1, 4'b0010, 8'hAC, 4'b0000);
    vec("beyond_y464",   100, 464, 1'b0, 4'b0000, 8'h00, 4'b0000);

    // Flash timing with FLASH_FRAMES=8, BLINK_PERIOD=2
    hit(4'b0001, 1'b0);
    vec("flash_start",   100, 20, 1'b1, 4'b0001, 8'hFF, 4'b0001);
    sof(2);
    vec("flash_sof2",    100, 20, 1'b1, 4'b0001, 8'hAC, 4'b0001);
    sof(2);
    vec("flash_sof4",    100, 20, 1'b1, 4'b0001, 8'hFF, 4'b0001);
    sof(3);
    vec("flash_sof7",    100, 20, 1'b1, 4'b0001, 8'hAC, 4'b0001);
    sof(1);
    vec("flash_end",     100, 20, 1'b1, 4'b0001, 8'hAC, 4'b0000);

    // Retrigger mid-flash reloads the full duration
    hit(4'b0001, 1'b0);
    sof(4);
    hit(4'b0001, 1'b0);
    vec("retrig_reload", 100, 20, 1'b1, 4'b0001, 8'hFF, 4'b0001);
    sof(7);
    vec("retrig_sof7",   100, 20, 1'b1, 4'b0001, 8'hAC, 4'b0001);
    sof(1);
    vec("retrig_end",    100, 20, 1'b1, 4'b0001, 8'hAC, 4'b0000);

    // Hit coincident with startOfFrame: reload wins
    hit(4'b0001, 1'b0);
    sof(3);
    hit(4'b0001, 1'b1);
    vec("coinc_reload",  100, 20, 1'b1, 4'b0001, 8'hFF, 4'b0001);
    sof(7);
    vec("coinc_sof7",    100, 20, 1'b1, 4'b0001, 8'hAC, 4'b0001);
    sof(1);
    vec("coinc_end",     100, 20, 1'b1, 4'b0001, 8'hAC, 4'b0000);

    // Left flashing: shared corner picks it up, pure top does not
    hit(4'b0100, 1'b0);
    vec("left_corner",   20,  20,  1'b1, 4'b0101, 8'hFF, 4'b0100);
    vec("left_top_only", 100, 20,  1'b1, 4'b0001, 8'hAC, 4'b0100);
    vec("left_side",     20,  200, 1'b1, 4'b0100, 8'hFF, 4'b0100);
    vec("right_idle",    608, 100, 1'b1, 4'b1000, 8'hAC, 4'b0100);

    // Asynchronous reset mid-flash
    hit(4'b1011, 1'b0);
    @(negedge clk);
    pixelX = 11'd100;
    pixelY = 11'd20;
    #2;
    resetN = 1'b0;
    #1;
    compare("async_reset", 1'b0, 4'b0000, 8'h00, 4'b0000);
    @(negedge clk);
    resetN = 1'b1;
    vec("post_reset",    100, 20, 1'b1, 4'b0001, 8'hAC, 4'b0000);
    vec("post_reset_r",  608, 100, 1'b1, 4'b1000, 8'hAC, 4'b0000);

`ifdef BORDER_POCKET_GAPS_EN
    vec("pocket_32_30",  32,  30, 1'b0, 4'b0000, 8'h00, 4'b0000);
    vec("pocket_mid",    319, 25, 1'b0, 4'b0000, 8'h00, 4'b0000);
    vec("no_pocket_100", 100, 25, 1'b1, 4'b0001, 8'hAC, 4'b0000);
`else
    vec("nogap_32_30",   32,  30, 1'b1, 4'b0001, 8'hAC, 4'b0000);
    vec("nogap_319_25",  319, 25, 1'b1, 4'b0001, 8'hAC, 4'b0000);
    vec("inner_31_31",   31,  31, 1'b1, 4'b0101, 8'hAC, 4'b0000);
    vec("inner_32_31",   32,  31, 1'b1, 4'b0001, 8'hAC, 4'b0000);
    vec("inner_31_32",   31,  32, 1'b1, 4'b0100, 8'hAC, 4'b0000);
    vec("inner_607_447", 607, 447, 1'b0, 4'b0000, 8'h00, 4'b0000);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/flashing_borders.md
Name: flashing_borders

Overview:
- Parametrised successor of the table border drawer.
- Draws a rectangular table frame of configurable thickness around an inner play area, and reports which side(s) each pixel belongs to.
- Each side flashes independently for a fixed number of frames after a ball-hit pulse.
- Sits in the background layer, feeding the object mux and the collision logic; outputs are registered, one clock of latency.

Parameters:
- LEFT_OFFSET, 32, first inner column of the play area
- RIGHT_OFFSET, 607, last inner column
- TOP_OFFSET, 32, first inner row
- DOWN_OFFSET, 447, last inner row
- THICKNESS, 16, frame width in pixels; elaboration error unless LEFT_OFFSET>=THICKNESS and TOP_OFFSET>=THICKNESS
- BORDER_COLOR, 8'hAC, idle frame colour (RGB332)
- FLASH_COLOR, 8'hFF, flash-phase colour
- FLASH_FRAMES, 8, flash duration in frames (1..255)
- BLINK_PERIOD, 2, frames per blink half-period (1..15)
- POCKET_RADIUS, 12, pocket half-size (POCKET_GAPS_EN only)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- pixelX  in  11  current pixel column
- pixelY  in  11  current pixel row
- hitTop, hitDown, hitLeft, hitRight  in  1 each  one-cycle hit pulses
- drawingRequestBorders  out  1  pixel is on the frame
- RGBoutBorders  out  8  pixel colour
- borderSide  out  4  one-hot-per-side {right,left,down,top}
- flashActive  out  4  side in FLASH state, same bit order

Behaviour:
- Side regions, inclusive, with TH=THICKNESS:
  - top: x in [L-TH, R+TH], y in [T-TH, T-1]
  - down: same x range, y in [D+1, D+TH]
  - left: x in [L-TH, L-1], y in [T-TH, D+TH]
  - right: x in [R+1, R+TH], same y range
- Corner squares set two borderSide bits. Pixels beyond the outer edge or inside the play area: all bits 0.
- drawingRequestBorders = OR of borderSide. All three pixel outputs registered: values at edge n+1 reflect pixelX/Y at edge n.
- Per-side FSM:
  - States IDLE, FLASH.
  - Registers: frameCnt (8b), blinkCnt (4b), phase (1b).
  - IDLE + hit: go to FLASH; frameCnt=FLASH_FRAMES, blinkCnt=0, phase=1.
  - FLASH + hit: reload the same values (retrigger).
  - FLASH + startOfFrame, no hit:
    - frameCnt decrements.
    - blinkCnt increments; at BLINK_PERIOD-1 it wraps to 0 and phase toggles.
    - If frameCnt was 1: go to IDLE, phase=0.
  - Hit and startOfFrame in the same cycle: reload wins, no decrement.
- Colour: FLASH_COLOR if any side covering the pixel is in FLASH with phase=1, else BORDER_COLOR. RGBoutBorders = 0 when not drawing. Uses FSM state before the current edge's update.
- flashActive is a registered copy of the FSM states.
- Reset (any time, including mid-flash): all FSMs IDLE, counters 0, phase 0, all outputs 0.
- Arithmetic: compare in 12-bit unsigned; no wrap possible given the elaboration check.

Optional Feature:
- Macro BORDER_POCKET_GAPS_EN.
- Defined: pixels with |x-px|<POCKET_RADIUS and |y-py|<POCKET_RADIUS are not drawn (drawingRequest=0, borderSide=0).
  - Pocket centres: (L,T), (R,T), (L,D), (R,D), (M,T), (M,D), with M=(L+R)>>1.
- Undefined: continuous frame, no gaps.

Test Plan:
- Pixels (100,20), (20,200), (20,20), (320,240), (5,5), one clock latency: drawingRequest 1/1/1/0/0; borderSide 0001/0100/0101/0000/0000; RGB AC/AC/AC/00/00.
- hitTop pulse, then pixel (100,20): flashActive=0001, RGB FF. Then:
  - After 2 startOfFrame: AC.
  - After 4: FF.
  - After the 8th: flashActive=0000, RGB AC.
- hitTop at frame 5 of a flash: counter reloads to 8, phase=1, RGB FF. Hit coincident with startOfFrame: frameCnt stays 8.
- hitLeft flashing, pixel (20,20): RGB FF (corner shared). Pixel (100,20): AC.
- resetN low mid-flash: all outputs 0 asynchronously. After release: flashActive 0000, pixel (100,20) → AC.
- (32,30):
  - With BORDER_POCKET_GAPS_EN: drawingRequest 0; (319,25) → 0; (100,25) → 1.
  - Without the macro: (32,30) → 1, side 0001.
